// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker producing issue grant/stall for a pipeline.
// Optional macro REG_SCOREBOARD_BYPASS_EN: a same-cycle write-back that retires a register's
// last pending write clears its busy status for hazard evaluation in that cycle.
module reg_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rs,
    input  logic [4:0]          issue_rt,
    input  logic                issue_uses_rs,
    input  logic                issue_uses_rt,
    input  logic                issue_writes,
    input  logic [4:0]          issue_wr_reg,
    input  logic                wb_valid,
    input  logic [4:0]          wb_reg,
    input  logic                flush,
    output logic                issue_grant,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [2:0]          inflight_count,
    output logic                err_wb_orphan
);
    logic [1:0] cnt_q [NUM_REGS];
    logic [1:0] cnt_d [NUM_REGS];
    logic       err_q, err_d;
    logic [1:0] cnt_rs, cnt_rt, cnt_wr, cnt_wb;
    logic       busy_rs, busy_rt, hazard, wb_in_range;

    // Look up counters for the addressed registers; out-of-range indices read as zero (never busy).
    always_comb begin
        cnt_rs = '0;
        cnt_rt = '0;
        cnt_wr = '0;
        cnt_wb = '0;
        busy_mask = '0;
        inflight_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_rs == 5'(i)) cnt_rs = cnt_q[i];
            if (issue_rt == 5'(i)) cnt_rt = cnt_q[i];
            if (issue_wr_reg == 5'(i)) cnt_wr = cnt_q[i];
            if (wb_reg == 5'(i)) cnt_wb = cnt_q[i];
            busy_mask[i] = |cnt_q[i];
            inflight_count = inflight_count + {1'b0, cnt_q[i]};
        end
    end

    assign wb_in_range = int'(wb_reg) < NUM_REGS;

`ifdef REG_SCOREBOARD_BYPASS_EN
    // A write-back retiring the last pending write forwards its result, so the source is free now.
    assign busy_rs = (cnt_rs != 2'd0) && !(wb_valid && wb_reg == issue_rs && cnt_rs == 2'd1);
    assign busy_rt = (cnt_rt != 2'd0) && !(wb_valid && wb_reg == issue_rt && cnt_rt == 2'd1);
`else
    assign busy_rs = cnt_rs != 2'd0;
    assign busy_rt = cnt_rt != 2'd0;
`endif

    // Hazard and handshake; both outputs are forced low while reset is asserted.
    always_comb begin
        hazard = (issue_uses_rs && busy_rs) || (issue_uses_rt && busy_rt) ||
                 (issue_writes && (cnt_wr == 2'd3 || inflight_count == 3'(MAX_INFLIGHT)));
        issue_grant = rst_n && issue_valid && !hazard && !flush;
        stall = rst_n && issue_valid && !issue_grant;
    end

    // Next counters: flush clears everything; simultaneous inc and dec cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            cnt_d[i] = flush ? 2'd0 :
                       cnt_q[i] + 2'((issue_grant && issue_writes && issue_wr_reg == 5'(i)) ? 1 : 0)
                                - 2'((wb_valid && wb_reg == 5'(i) && cnt_q[i] != 2'd0) ? 1 : 0);
        err_d = err_q || (wb_valid && !flush && wb_in_range && cnt_wb == 2'd0);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_wb_orphan = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_writes, wb_valid, flush;
    logic [4:0]  issue_rs, issue_rt, issue_wr_reg, wb_reg;
    logic        issue_grant, stall, err_wb_orphan;
    logic [15:0] busy_mask;
    logic [2:0]  inflight_count;
    int          checks = 0;
    int          failures = 0;
`ifdef REG_SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rt(issue_rt), .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
        .issue_writes(issue_writes), .issue_wr_reg(issue_wr_reg), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .flush(flush), .issue_grant(issue_grant), .stall(stall),
        .busy_mask(busy_mask), .inflight_count(inflight_count), .err_wb_orphan(err_wb_orphan)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_writes = 0; wb_valid = 0; flush = 0;
        issue_rs = 0; issue_rt = 0; issue_wr_reg = 0; wb_reg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic wr(input logic [4:0] r);
        idle();
        issue_valid = 1; issue_writes = 1; issue_wr_reg = r;
        #1;
    endtask

    task automatic rd(input logic [4:0] r);
        idle();
        issue_valid = 1; issue_uses_rs = 1; issue_rs = r;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        issue_valid = 1; issue_writes = 1; issue_wr_reg = 5'd2;
        #2;
        checks++; if (issue_grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0b exp=0", issue_grant); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        @(posedge clk); #1;
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL reset_mask got=%0h exp=0", busy_mask); end
        checks++; if (inflight_count !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_count); end
        checks++; if (err_wb_orphan !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_wb_orphan); end
        idle();
        rst_n = 1;
        #1;
    endtask

    task automatic test_raw();
        wr(5'd3);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL raw_wr_grant got=%0b exp=1", issue_grant); end
        tick();
        rd(5'd3);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%0b exp=1", stall); end
        checks++; if (busy_mask !== 16'h0008) begin failures++; $display("FAIL raw_mask got=%0h exp=8", busy_mask); end
        checks++; if (inflight_count !== 3'd1) begin failures++; $display("FAIL raw_inflight got=%0d exp=1", inflight_count); end
    endtask

    task automatic test_bypass();
        rd(5'd3);
        wb_valid = 1; wb_reg = 5'd3;
        #1;
        checks++; if (issue_grant !== BYP) begin failures++; $display("FAIL byp_grant got=%0b exp=%0b", issue_grant, BYP); end
        checks++; if (stall !== !BYP) begin failures++; $display("FAIL byp_stall got=%0b exp=%0b", stall, !BYP); end
        tick();
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL byp_mask got=%0h exp=0", busy_mask); end
        rd(5'd3);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL byp_late_grant got=%0b exp=1", issue_grant); end
        tick();
    endtask

    task automatic test_capacity();
        wr(5'd1); tick(); wr(5'd2); tick(); wr(5'd4); tick(); wr(5'd5); tick();
        checks++; if (inflight_count !== 3'd4) begin failures++; $display("FAIL cap_inflight got=%0d exp=4", inflight_count); end
        checks++; if (busy_mask !== 16'h0036) begin failures++; $display("FAIL cap_mask got=%0h exp=36", busy_mask); end
        wr(5'd6);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cap_stall got=%0b exp=1", stall); end
        tick();
        wr(5'd6); wb_valid = 1; wb_reg = 5'd1; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cap_stall_wb got=%0b exp=1", stall); end
        tick();
        checks++; if (inflight_count !== 3'd3) begin failures++; $display("FAIL cap_after_wb got=%0d exp=3", inflight_count); end
        wr(5'd6);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL cap_grant got=%0b exp=1", issue_grant); end
        tick();
        checks++; if (busy_mask !== 16'h0074) begin failures++; $display("FAIL cap_mask2 got=%0h exp=74", busy_mask); end
        idle(); flush = 1; tick();
        checks++; if (inflight_count !== 3'd0) begin failures++; $display("FAIL cap_flush got=%0d exp=0", inflight_count); end
    endtask

    task automatic test_saturate();
        wr(5'd1); tick(); wr(5'd1); tick(); wr(5'd1); tick();
        checks++; if (inflight_count !== 3'd3) begin failures++; $display("FAIL sat_inflight got=%0d exp=3", inflight_count); end
        wr(5'd1);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b exp=1", stall); end
        wr(5'd2);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL sat_other_grant got=%0b exp=1", issue_grant); end
        idle(); flush = 1; tick();
    endtask

    task automatic test_same_cycle();
        wr(5'd7); tick();
        wr(5'd7); wb_valid = 1; wb_reg = 5'd7; #1;
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL same_grant got=%0b exp=1", issue_grant); end
        tick();
        checks++; if (inflight_count !== 3'd1) begin failures++; $display("FAIL same_inflight got=%0d exp=1", inflight_count); end
        checks++; if (busy_mask !== 16'h0080) begin failures++; $display("FAIL same_mask got=%0h exp=80", busy_mask); end
        idle(); wb_valid = 1; wb_reg = 5'd7; tick();
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL same_retire got=%0h exp=0", busy_mask); end
    endtask

    task automatic test_orphan();
        wr(5'd20);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL oor_grant got=%0b exp=1", issue_grant); end
        tick();
        checks++; if (inflight_count !== 3'd0) begin failures++; $display("FAIL oor_inflight got=%0d exp=0", inflight_count); end
        idle(); wb_valid = 1; wb_reg = 5'd20; tick();
        checks++; if (err_wb_orphan !== 1'b0) begin failures++; $display("FAIL oor_err got=%0b exp=0", err_wb_orphan); end
        idle(); wb_valid = 1; wb_reg = 5'd9; tick();
        checks++; if (err_wb_orphan !== 1'b1) begin failures++; $display("FAIL orphan_err got=%0b exp=1", err_wb_orphan); end
        checks++; if (inflight_count !== 3'd0) begin failures++; $display("FAIL orphan_inflight got=%0d exp=0", inflight_count); end
        idle(); flush = 1; tick();
        checks++; if (err_wb_orphan !== 1'b1) begin failures++; $display("FAIL orphan_flush got=%0b exp=1", err_wb_orphan); end
        rst_n = 0; #2;
        checks++; if (err_wb_orphan !== 1'b0) begin failures++; $display("FAIL orphan_rst got=%0b exp=0", err_wb_orphan); end
        rst_n = 1; #1;
    endtask

    task automatic test_flush();
        wr(5'd1); tick(); wr(5'd2); tick(); wr(5'd3); tick();
        checks++; if (busy_mask !== 16'h000e) begin failures++; $display("FAIL fl_mask_pre got=%0h exp=e", busy_mask); end
        wr(5'd8); flush = 1; #1;
        checks++; if (issue_grant !== 1'b0) begin failures++; $display("FAIL fl_grant got=%0b exp=0", issue_grant); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL fl_mask got=%0h exp=0", busy_mask); end
        checks++; if (inflight_count !== 3'd0) begin failures++; $display("FAIL fl_inflight got=%0d exp=0", inflight_count); end
    endtask

    task automatic test_mid_reset();
        wr(5'd2); tick();
        checks++; if (busy_mask !== 16'h0004) begin failures++; $display("FAIL mr_mask_pre got=%0h exp=4", busy_mask); end
        rst_n = 0; #1;
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL mr_mask got=%0h exp=0", busy_mask); end
        rst_n = 1; #1;
        rd(5'd2);
        checks++; if (issue_grant !== 1'b1) begin failures++; $display("FAIL mr_grant got=%0b exp=1", issue_grant); end
        tick();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_bypass();
        test_capacity();
        test_saturate();
        test_same_cycle();
        test_orphan();
        test_flush();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
